// File: rtl/term_cmd_ctrl_pkg.sv
// Shared definitions for the terminal command controller:
//   - ASCII control codes recognised by the byte decoder
//   - vgachar data-type codes carried on dtype
//   - the {dtype,data} op word exchanged between decoder, queue and sequencer
//   - state encodings for the decode FSM and the strobe sequencer
package term_cmd_ctrl_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;
    localparam logic [7:0] ESC_Y    = 8'h59;
    localparam logic [7:0] ESC_E    = 8'h45;

    localparam logic [1:0] DT_CHAR = 2'd0;
    localparam logic [1:0] DT_COL  = 2'd1;
    localparam logic [1:0] DT_ROW  = 2'd2;

    typedef struct packed {
        logic [1:0] dtype;
        logic [7:0] data;
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_ESCY_R,
        ST_ESCY_C,
        ST_CLR
    } dec_state_t;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_SETUP,
        SQ_PULSE,
        SQ_HOLD
    } seq_state_t;

    function automatic op_t mk_op(input logic [1:0] dt, input logic [7:0] d);
        op_t o;
        o.dtype = dt;
        o.data  = d;
        return o;
    endfunction

endpackage

// File: rtl/term_cmd_ctrl_if.sv
// Bus between the byte source / vgachar peripheral and term_cmd_ctrl.
//   rx_data/rx_valid/rx_ready : incoming byte stream with ready/valid handshake
//   currow/curcol             : cursor position read back from vgachar
//   data/dtype/dstrobe        : vgachar write port
//   busy                      : controller has an op or clear sequence in flight
// master = byte source + vgachar side, slave = the controller.
interface term_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [5:0] currow;
    logic [6:0] curcol;
    logic [7:0] data;
    logic [1:0] dtype;
    logic       dstrobe;
    logic       busy;

    modport master (
        output rx_data, rx_valid, currow, curcol,
        input  rx_ready, data, dtype, dstrobe, busy
    );

    modport slave (
        input  rx_data, rx_valid, currow, curcol,
        output rx_ready, data, dtype, dstrobe, busy
    );
endinterface

// File: rtl/term_cmd_ctrl_strobe_seq.sv
// Drives one vgachar write: SETUP (1 cycle, data valid, strobe low),
// PULSE (PULSE_CYC cycles, strobe high), HOLD (1 cycle, strobe low).
// data/dtype are latched on start and held for the whole op.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, op       : launch an op; accepted when idle or in HOLD
//   idle            : no op in progress
//   done            : high during HOLD (last cycle of an op)
//   data, dtype     : registered vgachar data/type
//   dstrobe         : registered vgachar strobe
module term_cmd_ctrl_strobe_seq
    import term_cmd_ctrl_pkg::*;
#(
    parameter int PULSE_CYC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  op_t        op,
    output logic       idle,
    output logic       done,
    output logic [7:0] data,
    output logic [1:0] dtype,
    output logic       dstrobe
);

    localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);

    seq_state_t       phase, phase_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             dstrobe_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= SQ_IDLE;
            cnt     <= '0;
            dstrobe <= 1'b0;
            data    <= '0;
            dtype   <= '0;
        end else begin
            phase   <= phase_nx;
            cnt     <= cnt_nx;
            dstrobe <= dstrobe_nx;
            if (start && (phase == SQ_IDLE || phase == SQ_HOLD)) begin
                data  <= op.data;
                dtype <= op.dtype;
            end
        end
    end

    // dstrobe is a dedicated flop so vgachar never sees a decode glitch
    always_comb begin
        phase_nx   = phase;
        cnt_nx     = cnt;
        dstrobe_nx = 1'b0;
        case (phase)
            SQ_IDLE: begin
                if (start) phase_nx = SQ_SETUP;
            end
            SQ_SETUP: begin
                phase_nx   = SQ_PULSE;
                cnt_nx     = '0;
                dstrobe_nx = 1'b1;
            end
            SQ_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    phase_nx = SQ_HOLD;
                end else begin
                    cnt_nx     = cnt + 1'b1;
                    dstrobe_nx = 1'b1;
                end
            end
            SQ_HOLD: begin
                // a start here chains the next op with no idle gap
                phase_nx = start ? SQ_SETUP : SQ_IDLE;
            end
            default: phase_nx = SQ_IDLE;
        endcase
    end

    assign idle = (phase == SQ_IDLE);
    assign done = (phase == SQ_HOLD);

endmodule

// File: rtl/term_cmd_ctrl.sv
// Byte-stream command interpreter for the vgachar terminal.
// Turns printable ASCII into char writes, CR/LF/BS/TAB into cursor moves,
// ESC Y <row+32> <col+32> into absolute cursor addressing and ESC E into a
// full-screen clear followed by cursor home.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : term_cmd_ctrl_if slave (byte handshake, cursor readback,
//                vgachar write port, busy)
module term_cmd_ctrl
    import term_cmd_ctrl_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int PULSE_CYC = 8
) (
    input  logic           clk,
    input  logic           reset,
    term_cmd_ctrl_if.slave bus
);

    localparam int CLR_N = COLS * ROWS;
    localparam int CLR_W = $clog2(CLR_N + 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_N);
    localparam logic [7:0] COL_MAX = 8'(COLS - 1);
    localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);

    // ESC Y coordinate: byte-32, clamped to the last row/column when the
    // byte is below space or the result lands off-screen
    function automatic logic [7:0] clamp_coord(input logic [7:0] b, input logic [7:0] lim);
        logic [7:0] v;
        v = b - CH_SP;
        if (b < CH_SP || v > lim) return lim;
        return v;
    endfunction

    function automatic logic [7:0] tab_stop(input logic [6:0] col);
        logic [7:0] t;
        t = {1'b0, col | 7'h07} + 8'd1;
        return (t > COL_MAX) ? COL_MAX : t;
    endfunction

    function automatic logic [7:0] lf_row(input logic [5:0] row);
        return ({2'b00, row} == ROW_MAX) ? 8'd0 : {2'b00, row} + 8'd1;
    endfunction

    dec_state_t       state, state_nx;
    op_t              q_mem [0:1];
    logic             q_rd, q_wr;
    logic [1:0]       q_cnt;
    logic [7:0]       esc_row;
    logic [CLR_W-1:0] clr_cnt;

    logic seq_start, seq_idle, seq_done, seq_rdy;
    op_t  seq_op, push_op;
    logic push, pop, row_ld, clr_ld, clr_inc;
    logic ready_int, accept;
    logic [7:0] seq_data;
    logic [1:0] seq_dtype;
    logic       seq_dstrobe;

    term_cmd_ctrl_strobe_seq #(.PULSE_CYC(PULSE_CYC)) u_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (seq_start),
        .op      (seq_op),
        .idle    (seq_idle),
        .done    (seq_done),
        .data    (seq_data),
        .dtype   (seq_dtype),
        .dstrobe (seq_dstrobe)
    );

    assign seq_rdy   = seq_idle || seq_done;
    // new bytes only when nothing is pending, so cursor readback is settled
    assign ready_int = (state != ST_CLR) && (q_cnt == 2'd0) && seq_idle;
    assign accept    = bus.rx_valid && bus.rx_ready;

    assign bus.rx_ready = !reset && ready_int;
    assign bus.busy     = !reset && !ready_int;
    assign bus.data     = seq_data;
    assign bus.dtype    = seq_dtype;
    assign bus.dstrobe  = seq_dstrobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            q_rd    <= 1'b0;
            q_wr    <= 1'b0;
            q_cnt   <= 2'd0;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (push) q_wr <= ~q_wr;
            if (pop)  q_rd <= ~q_rd;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase
            if (clr_ld)       clr_cnt <= '0;
            else if (clr_inc) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)   q_mem[q_wr] <= push_op;
        if (row_ld) esc_row     <= clamp_coord(bus.rx_data, ROW_MAX);
    end

    // Queued ops take priority; the clear sequence and byte decode only issue
    // once the queue is empty. The first op of a byte bypasses the queue so a
    // single-op byte costs exactly one op time.
    always_comb begin
        state_nx  = state;
        seq_start = 1'b0;
        seq_op    = '0;
        push      = 1'b0;
        push_op   = '0;
        pop       = 1'b0;
        row_ld    = 1'b0;
        clr_ld    = 1'b0;
        clr_inc   = 1'b0;
        if (seq_rdy && q_cnt != 2'd0) begin
            seq_start = 1'b1;
            seq_op    = q_mem[q_rd];
            pop       = 1'b1;
        end else if (state == ST_CLR) begin
            if (seq_rdy) begin
                seq_start = 1'b1;
                if (clr_cnt != CLR_LAST) begin
                    seq_op  = mk_op(DT_CHAR, CH_SP);
                    clr_inc = 1'b1;
                end else begin
                    seq_op   = mk_op(DT_COL, 8'd0);
                    push     = 1'b1;
                    push_op  = mk_op(DT_ROW, 8'd0);
                    state_nx = ST_IDLE;
                end
            end
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_data >= CH_SP && bus.rx_data <= CH_TILDE) begin
                        seq_start = 1'b1;
                        seq_op    = mk_op(DT_CHAR, bus.rx_data);
                    end else begin
                        case (bus.rx_data)
                            CH_CR: begin
                                seq_start = 1'b1;
                                seq_op    = mk_op(DT_COL, 8'd0);
                            end
                            CH_LF: begin
                                seq_start = 1'b1;
                                seq_op    = mk_op(DT_ROW, lf_row(bus.currow));
                            end
                            CH_BS: begin
                                if (bus.curcol != 7'd0) begin
                                    seq_start = 1'b1;
                                    seq_op    = mk_op(DT_COL, {1'b0, bus.curcol - 7'd1});
                                end
                            end
                            CH_TAB: begin
                                seq_start = 1'b1;
                                seq_op    = mk_op(DT_COL, tab_stop(bus.curcol));
                            end
                            CH_ESC:  state_nx = ST_ESC;
                            default: ;
                        endcase
                    end
                end
                ST_ESC: begin
                    if (bus.rx_data == ESC_Y) begin
                        state_nx = ST_ESCY_R;
                    end else if (bus.rx_data == ESC_E) begin
                        seq_start = 1'b1;
                        seq_op    = mk_op(DT_COL, 8'd0);
                        push      = 1'b1;
                        push_op   = mk_op(DT_ROW, 8'd0);
                        clr_ld    = 1'b1;
                        state_nx  = ST_CLR;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ESCY_R: begin
                    row_ld   = 1'b1;
                    state_nx = ST_ESCY_C;
                end
                ST_ESCY_C: begin
                    seq_start = 1'b1;
                    seq_op    = mk_op(DT_COL, clamp_coord(bus.rx_data, COL_MAX));
                    push      = 1'b1;
                    push_op   = mk_op(DT_ROW, esc_row);
                    state_nx  = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule
